// File: rtl/sfp_port_ctrl.sv
// sfp_port_ctrl -- SFP+ cage power-up / fault sequencer, one independent FSM per cage.
//
// Purpose: debounce module insertion and time the SFP TX init window. Hold the GT
// lane in reset until the optics are up. Recover from TX_FAULT by pulsing TX_DISABLE
// for t_reset, with a bounded number of retries. Latch LOCKOUT once the retries are
// used up; management releases it with Clear_lockout.
//
// Ports (per cage i unless noted):
//   clk, rst       system clock, synchronous active-high reset
//   Port_en        management enable; low forces OFF and clears the retry count
//   Rate_10g       rate select, mirrored to RS one clock later
//   Clear_lockout  1-cycle pulse, only acted on in LOCKOUT
//   MOD_ABS        async pin, 1 = cage empty
//   TX_FAULT       async pin, 1 = module TX fault
//   RX_LOS         async pin, 1 = loss of signal
//   TX_DISABLE     1 = laser off (low only in INIT/UP)
//   RS             rate select to the module
//   Gt_rst         GT lane reset (low only in UP)
//   Port_up        UP and no RX_LOS
//   Port_lockout   port is in LOCKOUT
//   Port_state     FSM state, port i at [3i+2:3i]
//   Retry_cnt      fault recoveries so far, port i at [4i+3:4i]
//
// Parameter ranges: all *_CYC values must be in 1..2^24-1; MAX_RETRY must be in 1..15.

// Single-cage sequencer
module sfp_port_lane #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int TINIT_CYC    = 50000,
  parameter int TRESET_CYC   = 1000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       port_en,
  input  logic       rate_10g,
  input  logic       clear_lockout,
  input  logic       mod_abs,
  input  logic       tx_fault,
  input  logic       rx_los,
  output logic       tx_disable,
  output logic       rs,
  output logic       gt_rst,
  output logic       port_up,
  output logic       port_lockout,
  output logic [2:0] port_state,
  output logic [3:0] retry_cnt
);
  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_ABSENT     = 3'd1,
    ST_DEBOUNCE   = 3'd2,
    ST_INIT       = 3'd3,
    ST_UP         = 3'd4,
    ST_FAULT_HOLD = 3'd5,
    ST_LOCKOUT    = 3'd6
  } state_t;

  localparam logic [23:0] DEB_LAST   = 24'(DEBOUNCE_CYC - 1);
  localparam logic [23:0] TINIT_LAST = 24'(TINIT_CYC - 1);
  localparam logic [23:0] TRST_LAST  = 24'(TRESET_CYC - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

  state_t      state, nxt_state;
  logic [23:0] timer, nxt_timer;
  logic [3:0]  retry, nxt_retry, retry_inc;
  logic [1:0]  mod_abs_q, tx_fault_q, rx_los_q;
  logic        mod_abs_s, tx_fault_s, rx_los_s;

  assign mod_abs_s  = mod_abs_q[1];
  assign tx_fault_s = tx_fault_q[1];
  assign rx_los_s   = rx_los_q[1];
  assign port_state = state;
  assign retry_cnt  = retry;

  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    nxt_retry = retry;
    retry_inc = (retry == 4'hF) ? retry : retry + 4'd1;
    if (!port_en) begin
      nxt_state = ST_OFF;
      nxt_timer = '0;
      nxt_retry = '0;
    end else if (mod_abs_s && state != ST_OFF && state != ST_ABSENT) begin
      // Removal (or an insertion bounce) aborts whatever the port was doing.
      nxt_state = ST_ABSENT;
      nxt_timer = '0;
      nxt_retry = '0;
    end else begin
      case (state)
        ST_OFF: nxt_state = ST_ABSENT;
        ST_ABSENT: begin
          if (!mod_abs_s) begin
            nxt_state = ST_DEBOUNCE;
            nxt_timer = '0;
          end
        end
        ST_DEBOUNCE: begin
          if (timer == DEB_LAST) begin
            nxt_state = ST_INIT;
            nxt_timer = '0;
          end else begin
            nxt_timer = timer + 24'd1;
          end
        end
        ST_INIT: begin
          // TX_FAULT is only meaningful once t_init has elapsed.
          if (timer == TINIT_LAST) begin
            nxt_timer = '0;
            if (tx_fault_s) begin
              nxt_state = ST_FAULT_HOLD;
              nxt_retry = retry_inc;
            end else begin
              nxt_state = ST_UP;
            end
          end else begin
            nxt_timer = timer + 24'd1;
          end
        end
        ST_UP: begin
          if (tx_fault_s) begin
            nxt_state = ST_FAULT_HOLD;
            nxt_retry = retry_inc;
            nxt_timer = '0;
          end
        end
        ST_FAULT_HOLD: begin
          if (timer == TRST_LAST) begin
            nxt_timer = '0;
            nxt_state = (retry >= RETRY_MAX) ? ST_LOCKOUT : ST_INIT;
          end else begin
            nxt_timer = timer + 24'd1;
          end
        end
        ST_LOCKOUT: begin
          if (clear_lockout) begin
            nxt_state = ST_ABSENT;
            nxt_retry = '0;
          end
        end
        default: begin
          nxt_state = ST_OFF;
          nxt_timer = '0;
          nxt_retry = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with Port_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mod_abs_q    <= 2'b11;
      tx_fault_q   <= 2'b00;
      rx_los_q     <= 2'b11;
      state        <= ST_OFF;
      timer        <= '0;
      retry        <= '0;
      tx_disable   <= 1'b1;
      gt_rst       <= 1'b1;
      rs           <= 1'b1;
      port_up      <= 1'b0;
      port_lockout <= 1'b0;
    end else begin
      mod_abs_q    <= {mod_abs_q[0], mod_abs};
      tx_fault_q   <= {tx_fault_q[0], tx_fault};
      rx_los_q     <= {rx_los_q[0], rx_los};
      state        <= nxt_state;
      timer        <= nxt_timer;
      retry        <= nxt_retry;
      tx_disable   <= !(nxt_state == ST_INIT || nxt_state == ST_UP);
      gt_rst       <= (nxt_state != ST_UP);
      rs           <= rate_10g;
      port_up      <= (nxt_state == ST_UP) && !rx_los_s;
      port_lockout <= (nxt_state == ST_LOCKOUT);
    end
  end
endmodule

// Top level: one sfp_port_lane per cage
module sfp_port_ctrl #(
  parameter int N_PORTS      = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int TINIT_CYC    = 50000,
  parameter int TRESET_CYC   = 1000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   Port_en,
  input  logic [N_PORTS-1:0]   Rate_10g,
  input  logic [N_PORTS-1:0]   Clear_lockout,
  input  logic [N_PORTS-1:0]   MOD_ABS,
  input  logic [N_PORTS-1:0]   TX_FAULT,
  input  logic [N_PORTS-1:0]   RX_LOS,
  output logic [N_PORTS-1:0]   TX_DISABLE,
  output logic [N_PORTS-1:0]   RS,
  output logic [N_PORTS-1:0]   Gt_rst,
  output logic [N_PORTS-1:0]   Port_up,
  output logic [N_PORTS-1:0]   Port_lockout,
  output logic [3*N_PORTS-1:0] Port_state,
  output logic [4*N_PORTS-1:0] Retry_cnt
);
  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
      sfp_port_lane #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .TINIT_CYC    (TINIT_CYC),
        .TRESET_CYC   (TRESET_CYC),
        .MAX_RETRY    (MAX_RETRY)
      ) u_lane (
        .clk           (clk),
        .rst           (rst),
        .port_en       (Port_en[i]),
        .rate_10g      (Rate_10g[i]),
        .clear_lockout (Clear_lockout[i]),
        .mod_abs       (MOD_ABS[i]),
        .tx_fault      (TX_FAULT[i]),
        .rx_los        (RX_LOS[i]),
        .tx_disable    (TX_DISABLE[i]),
        .rs            (RS[i]),
        .gt_rst        (Gt_rst[i]),
        .port_up       (Port_up[i]),
        .port_lockout  (Port_lockout[i]),
        .port_state    (Port_state[3*i +: 3]),
        .retry_cnt     (Retry_cnt[4*i +: 4])
      );
    end
  endgenerate
endmodule

// File: tb/tb_sfp_port_ctrl.sv
// Bench for sfp_port_ctrl with DEBOUNCE_CYC=8, TINIT_CYC=16, TRESET_CYC=4, MAX_RETRY=2.
// Expected per-port results are hand-timed and queued with the cycle they fall due.
// They are popped and compared on the falling edge of that cycle.
module tb_sfp_port_ctrl;
  localparam int NP = 4;

  logic clk, rst;
  logic [NP-1:0]   Port_en, Rate_10g, Clear_lockout, MOD_ABS, TX_FAULT, RX_LOS;
  logic [NP-1:0]   TX_DISABLE, RS, Gt_rst, Port_up, Port_lockout;
  logic [3*NP-1:0] Port_state;
  logic [4*NP-1:0] Retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // want = {state[2:0], retry[3:0], tx_disable, gt_rst, port_up, lockout}
  typedef struct {
    int          due;
    int          port;
    logic [10:0] want;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [10:0] mon_act;

  typedef struct {
    logic [3:0]  rate;
    logic [3:0]  clr;
    logic [3:0]  exp_rs;
    logic [11:0] exp_st;
  } vec_t;
  vec_t vecs[5];

  sfp_port_ctrl #(
    .N_PORTS(NP), .DEBOUNCE_CYC(8), .TINIT_CYC(16), .TRESET_CYC(4), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .Port_en(Port_en), .Rate_10g(Rate_10g),
    .Clear_lockout(Clear_lockout), .MOD_ABS(MOD_ABS), .TX_FAULT(TX_FAULT),
    .RX_LOS(RX_LOS), .TX_DISABLE(TX_DISABLE), .RS(RS), .Gt_rst(Gt_rst),
    .Port_up(Port_up), .Port_lockout(Port_lockout), .Port_state(Port_state),
    .Retry_cnt(Retry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      mon_act = {Port_state[mon_e.port*3 +: 3], Retry_cnt[mon_e.port*4 +: 4],
                 TX_DISABLE[mon_e.port], Gt_rst[mon_e.port], Port_up[mon_e.port],
                 Port_lockout[mon_e.port]};
      checks++;
      if (mon_e.due != cyc) begin
        errors++;
        $display("FAIL %s port%0d: due cycle %0d, reached at %0d", mon_e.name, mon_e.port,
                 mon_e.due, cyc);
      end else if (mon_act !== mon_e.want) begin
        errors++;
        $display("FAIL %s port%0d cyc %0d: got st=%0d rc=%0d txd/gt/up/lck=%b want st=%0d rc=%0d txd/gt/up/lck=%b",
                 mon_e.name, mon_e.port, cyc, mon_act[10:8], mon_act[7:4], mon_act[3:0],
                 mon_e.want[10:8], mon_e.want[7:4], mon_e.want[3:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Queue an expectation dly clocks from now, kept sorted by due cycle.
  task automatic push(input int dly, input int p, input logic [2:0] st, input logic [3:0] rc,
                      input logic txd, input logic gtr, input logic up, input logic lck,
                      input string nm);
    exp_t e;
    int   i;
    e.due  = cyc + dly;
    e.port = p;
    e.want = {st, rc, txd, gtr, up, lck};
    e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endtask

  initial begin
    rst = 1'b1;
    Port_en = '0; Rate_10g = '0; Clear_lockout = '0;
    MOD_ABS = '1; TX_FAULT = '0; RX_LOS = '0;
    vecs[0] = '{rate: 4'h0, clr: 4'hF, exp_rs: 4'h0, exp_st: 12'h000};
    vecs[1] = '{rate: 4'hA, clr: 4'h0, exp_rs: 4'hA, exp_st: 12'h000};
    vecs[2] = '{rate: 4'h5, clr: 4'hF, exp_rs: 4'h5, exp_st: 12'h000};
    vecs[3] = '{rate: 4'hF, clr: 4'h0, exp_rs: 4'hF, exp_st: 12'h000};
    vecs[4] = '{rate: 4'h3, clr: 4'h0, exp_rs: 4'h3, exp_st: 12'h000};

    // Reset values
    tick(3);
    chk("rst_tx_disable", 16'(TX_DISABLE), 16'hF);
    chk("rst_gt_rst", 16'(Gt_rst), 16'hF);
    chk("rst_rs", 16'(RS), 16'hF);
    chk("rst_state", 16'(Port_state), 16'h0);
    chk("rst_retry", 16'(Retry_cnt), 16'h0);
    chk("rst_port_up", 16'(Port_up), 16'h0);
    chk("rst_lockout", 16'(Port_lockout), 16'h0);
    rst = 1'b0;

    // RS follows Rate_10g by one clock; Clear_lockout ignored while OFF
    for (int i = 0; i < 5; i++) begin
      Rate_10g = vecs[i].rate;
      Clear_lockout = vecs[i].clr;
      tick(1);
      chk("rs_track", 16'(RS), 16'(vecs[i].exp_rs));
      chk("off_state", 16'(Port_state), 16'(vecs[i].exp_st));
      chk("off_tx_disable", 16'(TX_DISABLE), 16'hF);
    end
    Clear_lockout = '0;

    // Port 0: insertion with a bounce, debounce restart, INIT, UP
    Port_en[0] = 1'b1;
    push(1, 0, 3'd1, 4'd0, 1, 1, 0, 0, "t2_absent");
    tick(1);
    MOD_ABS[0] = 1'b0;
    push(3, 0, 3'd2, 4'd0, 1, 1, 0, 0, "t2_deb_first");
    push(6, 0, 3'd1, 4'd0, 1, 1, 0, 0, "t2_bounce_absent");
    tick(3);
    MOD_ABS[0] = 1'b1;
    tick(2);
    MOD_ABS[0] = 1'b0;
    push(2,  0, 3'd1, 4'd0, 1, 1, 0, 0, "t2_still_absent");
    push(3,  0, 3'd2, 4'd0, 1, 1, 0, 0, "t2_deb_restart");
    push(6,  0, 3'd2, 4'd0, 1, 1, 0, 0, "t2_no_early_init");
    push(10, 0, 3'd2, 4'd0, 1, 1, 0, 0, "t2_deb_last");
    push(11, 0, 3'd3, 4'd0, 0, 1, 0, 0, "t2_init");
    push(26, 0, 3'd3, 4'd0, 0, 1, 0, 0, "t2_init_last");
    push(27, 0, 3'd4, 4'd0, 0, 0, 1, 0, "t2_up");
    tick(27);

    // Port 0: one-clock TX_FAULT in UP -> 4-clock hold -> INIT -> UP
    TX_FAULT[0] = 1'b1;
    push(2,  0, 3'd4, 4'd0, 0, 0, 1, 0, "t3_up_before");
    push(3,  0, 3'd5, 4'd1, 1, 1, 0, 0, "t3_hold");
    push(6,  0, 3'd5, 4'd1, 1, 1, 0, 0, "t3_hold_last");
    push(7,  0, 3'd3, 4'd1, 0, 1, 0, 0, "t3_reinit");
    push(22, 0, 3'd3, 4'd1, 0, 1, 0, 0, "t3_reinit_last");
    push(23, 0, 3'd4, 4'd1, 0, 0, 1, 0, "t3_up_again");
    tick(1);
    TX_FAULT[0] = 1'b0;
    tick(22);

    // Port 0: RX_LOS drops Port_up only; removal beats a simultaneous fault
    RX_LOS[0] = 1'b1;
    push(2, 0, 3'd4, 4'd1, 0, 0, 1, 0, "t6_los_pending");
    push(3, 0, 3'd4, 4'd1, 0, 0, 0, 0, "t6_los_down");
    tick(3);
    RX_LOS[0] = 1'b0;
    push(3, 0, 3'd4, 4'd1, 0, 0, 1, 0, "t6_los_clear");
    tick(3);
    TX_FAULT[0] = 1'b1;
    MOD_ABS[0] = 1'b1;
    push(3, 0, 3'd1, 4'd0, 1, 1, 0, 0, "t6_abs_wins");
    push(4, 0, 3'd1, 4'd0, 1, 1, 0, 0, "t6_abs_stays");
    tick(1);
    TX_FAULT[0] = 1'b0;
    tick(4);
    Clear_lockout[0] = 1'b1;
    push(1, 0, 3'd1, 4'd0, 1, 1, 0, 0, "t6_clr_ignored");
    tick(1);
    Clear_lockout[0] = 1'b0;

    // Port 1: stuck TX_FAULT -> two retries -> LOCKOUT -> Clear_lockout
    Port_en[1] = 1'b1;
    MOD_ABS[1] = 1'b0;
    TX_FAULT[1] = 1'b1;
    push(1,  1, 3'd1, 4'd0, 1, 1, 0, 0, "t4_absent");
    push(3,  1, 3'd2, 4'd0, 1, 1, 0, 0, "t4_deb");
    push(11, 1, 3'd3, 4'd0, 0, 1, 0, 0, "t4_init");
    push(27, 1, 3'd5, 4'd1, 1, 1, 0, 0, "t4_fault1");
    push(31, 1, 3'd3, 4'd1, 0, 1, 0, 0, "t4_reinit");
    push(47, 1, 3'd5, 4'd2, 1, 1, 0, 0, "t4_fault2");
    push(50, 1, 3'd5, 4'd2, 1, 1, 0, 0, "t4_hold_last");
    push(51, 1, 3'd6, 4'd2, 1, 1, 0, 1, "t4_lockout");
    push(60, 1, 3'd6, 4'd2, 1, 1, 0, 1, "t4_lock_held");
    tick(28);
    Clear_lockout[1] = 1'b1;  // in FAULT_HOLD: must be ignored
    tick(1);
    Clear_lockout[1] = 1'b0;
    tick(31);
    Clear_lockout[1] = 1'b1;
    push(1, 1, 3'd1, 4'd0, 1, 1, 0, 0, "t4_cleared");
    push(2, 1, 3'd2, 4'd0, 1, 1, 0, 0, "t4_redebounce");
    tick(1);
    Clear_lockout[1] = 1'b0;
    tick(1);
    Port_en[1] = 1'b0;
    TX_FAULT[1] = 1'b0;
    MOD_ABS[1] = 1'b1;
    push(1, 1, 3'd0, 4'd0, 1, 1, 0, 0, "t4_off");
    tick(1);

    // Ports 2/3 in parallel; port 2 disabled mid-INIT, port 3 carries on
    Port_en[3:2] = 2'b11;
    MOD_ABS[3:2] = 2'b00;
    push(11, 2, 3'd3, 4'd0, 0, 1, 0, 0, "t5_init_p2");
    push(11, 3, 3'd3, 4'd0, 0, 1, 0, 0, "t5_init_p3");
    tick(16);
    Port_en[2] = 1'b0;
    push(1,  2, 3'd0, 4'd0, 1, 1, 0, 0, "t5_off_p2");
    push(1,  3, 3'd3, 4'd0, 0, 1, 0, 0, "t5_p3_init");
    push(11, 3, 3'd4, 4'd0, 0, 0, 1, 0, "t5_p3_up");
    tick(11);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expectations want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
